pll_ctrl: RTL

- Sequences the on-board clock PLL: holds PLL reset for a minimum time, waits for LOCKED with a timeout and bounded retries, and qualifies lock before declaring clocks ready.
- Owns the select and enable for the forwarded clock (the PLL output mux and the ODDR2 CE feeding the clock pin); performs glitch-safe output switching.
- Runs entirely on the 50 MHz board clock, never on a PLL output.

---
 rtl/pll_ctrl_if.sv | 11 +
 rtl/pll_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pll_ctrl_if.sv
// Clock-select request channel between a requester and pll_ctrl.
// The requester drives sel_req/sel_valid; the controller answers with sel_ready/sel_err.
interface pll_ctrl_if;
  logic [2:0] sel_req;
  logic       sel_valid;
  logic       sel_ready;
  logic       sel_err;

  modport master (output sel_req, output sel_valid, input sel_ready, input sel_err);
  modport slave  (input sel_req, input sel_valid, output sel_ready, output sel_err);
endinterface

// File: rtl/pll_ctrl.sv
// PLL bring-up sequencer and glitch-safe forwarded-clock select, running on the board clock.
// Handles reset hold, lock wait with bounded retries, lock qualification and lock-loss recovery.
module pll_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int MAX_RETRY     = 3,
  parameter int SETTLE_CYCLES = 8,
  parameter int SWITCH_GAP    = 4,
  parameter int NUM_CLK       = 6,
  parameter int SEL_DEFAULT   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  pll_ctrl_if.slave  sel_if,
  output logic       pll_reset,
  output logic [2:0] clk_sel,
  output logic       fwd_en,
  output logic       ready,
  output logic       lock_lost,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(LOCK_TIMEOUT, RST_CYCLES), max2(SETTLE_CYCLES, 2 * SWITCH_GAP));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_MID     = CNT_W'(SWITCH_GAP - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(2 * SWITCH_GAP - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);
  localparam logic [3:0]       NUM_CLK_V   = 4'(NUM_CLK);
  localparam logic [2:0]       SEL_RST     = 3'(SEL_DEFAULT);

  localparam logic [2:0] RESET_HOLD = 3'd0;
  localparam logic [2:0] WAIT_LOCK  = 3'd1;
  localparam logic [2:0] SETTLE     = 3'd2;
  localparam logic [2:0] RUN        = 3'd3;
  localparam logic [2:0] SW_GAP     = 3'd4;
  localparam logic [2:0] FAIL_ST    = 3'd5;

  function automatic logic sel_out_of_range(input logic [2:0] s);
    return {1'b0, s} >= NUM_CLK_V;
  endfunction

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             lock_sync_p0;
  logic             locked_s;
  logic [2:0]       pending_sel;
  logic             accept;

  // Stage boundary: pll_locked is asynchronous, two flops before any decision uses it
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync_p0 <= 1'b0;
      locked_s     <= 1'b0;
    end else begin
      lock_sync_p0 <= pll_locked;
      locked_s     <= lock_sync_p0;
    end
  end

  assign accept = (state == RUN) && sel_if.sel_valid && sel_if.sel_ready;

  always_ff @(posedge clk) begin
    if (accept) pending_sel <= sel_if.sel_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RESET_HOLD;
      cnt              <= '0;
      pll_reset        <= 1'b1;
      clk_sel          <= SEL_RST;
      fwd_en           <= 1'b0;
      ready            <= 1'b0;
      sel_if.sel_ready <= 1'b0;
      sel_if.sel_err   <= 1'b0;
      lock_lost        <= 1'b0;
      fail             <= 1'b0;
      retry_cnt        <= 2'd0;
    end else begin
      sel_if.sel_err <= 1'b0;
      lock_lost      <= 1'b0;
      case (state)
        RESET_HOLD: begin
          if (cnt == RST_LAST) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= SETTLE;
            cnt   <= '0;
          end else if (cnt == LOCK_LAST) begin
            cnt       <= '0;
            pll_reset <= 1'b1;
            if (retry_cnt == RETRY_MAX) begin
              state <= FAIL_ST;
              fail  <= 1'b1;
            end else begin
              state     <= RESET_HOLD;
              retry_cnt <= retry_cnt + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          // A dropout restarts the lock wait without consuming a retry
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == SETTLE_LAST) begin
            state            <= RUN;
            cnt              <= '0;
            ready            <= 1'b1;
            fwd_en           <= 1'b1;
            sel_if.sel_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN, SW_GAP: begin
          if (!locked_s) begin
            state            <= RESET_HOLD;
            cnt              <= '0;
            pll_reset        <= 1'b1;
            ready            <= 1'b0;
            fwd_en           <= 1'b0;
            sel_if.sel_ready <= 1'b0;
            lock_lost        <= 1'b1;
            retry_cnt        <= 2'd0;
          end else if (state == RUN) begin
            if (accept) begin
              if (sel_out_of_range(sel_if.sel_req)) begin
                sel_if.sel_err <= 1'b1;
              end else if (sel_if.sel_req != clk_sel) begin
                state            <= SW_GAP;
                cnt              <= '0;
                fwd_en           <= 1'b0;
                sel_if.sel_ready <= 1'b0;
              end
            end
          end else begin
            // Mux changes only in the middle of the quiet window, with the forward gated off
            if (cnt == GAP_MID) clk_sel <= pending_sel;
            if (cnt == GAP_LAST) begin
              state            <= RUN;
              cnt              <= '0;
              fwd_en           <= 1'b1;
              sel_if.sel_ready <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FAIL_ST: begin
          pll_reset        <= 1'b1;
          fail             <= 1'b1;
          fwd_en           <= 1'b0;
          ready            <= 1'b0;
          sel_if.sel_ready <= 1'b0;
        end
        default: begin
          state     <= RESET_HOLD;
          cnt       <= '0;
          pll_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
